// File: rtl/acc_arbiter.sv
// Two-requester round-robin arbiter fronting a shared 16-bit accumulator.
// Each granted operation runs IDLE -> EXEC -> RESP and ends with a one-cycle done pulse.
module acc_arbiter #(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_a,
  input  logic              req_b,
  input  logic [1:0]        op_a,
  input  logic [1:0]        op_b,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  input  logic              clr,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              done,
  output logic              owner,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] acc_out,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] acc, acc_nxt;
  logic [1:0]        op_p0;
  logic [DATA_W-1:0] data_p0;
  logic              win, win_nxt;
  logic              last_b, last_b_nxt;
  logic              gnt_a_nxt, gnt_b_nxt, done_nxt;
  logic              latch_en;
  logic              pick_b;

  // Wraps modulo 2^DATA_W; no carry or borrow is kept.
  function automatic logic [DATA_W-1:0] alu(input logic [1:0] op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    case (op)
      2'd0:    r = a + b;
      2'd1:    r = a - b;
      2'd2:    r = a & b;
      default: r = a | b;
    endcase
    return r;
  endfunction

  // On a tie the side not served last wins.
  assign pick_b = req_b && (!req_a || !last_b);

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    win_nxt    = win;
    last_b_nxt = last_b;
    gnt_a_nxt  = 1'b0;
    gnt_b_nxt  = 1'b0;
    done_nxt   = 1'b0;
    latch_en   = 1'b0;
    case (state)
      IDLE: begin
        if (clr) begin
          acc_nxt = '0;
        end else if (req_a || req_b) begin
          win_nxt   = pick_b;
          gnt_a_nxt = !pick_b;
          gnt_b_nxt = pick_b;
          latch_en  = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        acc_nxt   = alu(op_p0, acc, data_p0);
        done_nxt  = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        last_b_nxt = win;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= IDLE;
      acc    <= '0;
      win    <= 1'b0;
      last_b <= 1'b1;
      gnt_a  <= 1'b0;
      gnt_b  <= 1'b0;
      done   <= 1'b0;
      owner  <= 1'b0;
      result <= '0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      win    <= win_nxt;
      last_b <= last_b_nxt;
      gnt_a  <= gnt_a_nxt;
      gnt_b  <= gnt_b_nxt;
      done   <= done_nxt;
      if (done_nxt) begin
        owner  <= win;
        result <= acc_nxt;
      end
    end
  end

  // Operand capture stage: held steady through EXEC regardless of input changes.
  always_ff @(posedge clock) begin
    if (latch_en) begin
      op_p0   <= pick_b ? op_b : op_a;
      data_p0 <= pick_b ? data_b : data_a;
    end
  end

  assign acc_out = acc;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_acc_arbiter.sv
// Directed bench for acc_arbiter: reset, single request, tie rotation, wrap,
// reset mid-operation and clear priority, with hand-computed expectations.
module tb_acc_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_a, req_b;
  logic [1:0]  op_a, op_b;
  logic [15:0] data_a, data_b;
  logic        clr;
  logic        gnt_a, gnt_b, done, owner, busy;
  logic [15:0] result, acc_out;

  int total = 0;
  int bad   = 0;

  acc_arbiter dut (
    .clock  (clock),
    .reset  (reset),
    .req_a  (req_a),
    .req_b  (req_b),
    .op_a   (op_a),
    .op_b   (op_b),
    .data_a (data_a),
    .data_b (data_b),
    .clr    (clr),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b),
    .done   (done),
    .owner  (owner),
    .result (result),
    .acc_out(acc_out),
    .busy   (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later; always check the grant/done exclusions.
  task automatic step();
    @(posedge clock);
    #1;
    chk("gnt_excl", {15'd0, gnt_a & gnt_b}, 16'd0);
    chk("done_gnt_excl", {15'd0, done & (gnt_a | gnt_b)}, 16'd0);
  endtask

  // One full transaction from one side; inputs are disturbed during EXEC to prove latching.
  task automatic op_cycle(input logic side, input logic [1:0] op, input logic [15:0] d,
                          input logic [15:0] exp_res);
    if (side) begin req_b = 1'b1; op_b = op; data_b = d; end
    else      begin req_a = 1'b1; op_a = op; data_a = d; end
    step();
    chk("op_gnt_a", {15'd0, gnt_a}, {15'd0, !side});
    chk("op_gnt_b", {15'd0, gnt_b}, {15'd0, side});
    chk("op_busy", {15'd0, busy}, 16'd1);
    req_a = 1'b0; req_b = 1'b0;
    data_a = 16'hDEAD; data_b = 16'hBEEF; op_a = 2'd3; op_b = 2'd3;
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("op_done", {15'd0, done}, 16'd1);
    chk("op_result", result, exp_res);
    chk("op_owner", {15'd0, owner}, {15'd0, side});
    chk("op_acc", acc_out, exp_res);
    step();
    chk("op_done_clr", {15'd0, done}, 16'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; clr = 1'b0;
    req_a = 1'b1; req_b = 1'b0;
    op_a = 2'd0; op_b = 2'd0; data_a = 16'h0005; data_b = 16'h0000;
    #1;
    step();
    step();
    chk("rst_acc", acc_out, 16'h0000);
    chk("rst_gnt_a", {15'd0, gnt_a}, 16'd0);
    chk("rst_gnt_b", {15'd0, gnt_b}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_result", result, 16'h0000);
    chk("rst_owner", {15'd0, owner}, 16'd0);

    // Single request: acc 0 + 5
    reset = 1'b1;
    op_cycle(1'b0, 2'd0, 16'h0005, 16'h0005);
    chk("single_idle", {15'd0, busy}, 16'd0);

    // Tie and rotation from reset
    do_reset();
    req_a = 1'b1; op_a = 2'd0; data_a = 16'h0003;
    req_b = 1'b1; op_b = 2'd1; data_b = 16'h0001;
    step();
    chk("tie1_gnt_a", {15'd0, gnt_a}, 16'd1);
    chk("tie1_gnt_b", {15'd0, gnt_b}, 16'd0);
    req_a = 1'b0;
    step();
    chk("tie1_done", {15'd0, done}, 16'd1);
    chk("tie1_result", result, 16'h0003);
    chk("tie1_owner", {15'd0, owner}, 16'd0);
    step();
    chk("tie_gap_gnt_b", {15'd0, gnt_b}, 16'd0);
    chk("tie_gap_busy", {15'd0, busy}, 16'd0);
    step();
    chk("tie2_gnt_b", {15'd0, gnt_b}, 16'd1);
    chk("tie2_gnt_a", {15'd0, gnt_a}, 16'd0);
    req_b = 1'b0;
    step();
    chk("tie2_done", {15'd0, done}, 16'd1);
    chk("tie2_result", result, 16'h0002);
    chk("tie2_owner", {15'd0, owner}, 16'd1);
    step();
    req_a = 1'b1; op_a = 2'd0; data_a = 16'h0010;
    req_b = 1'b1; op_b = 2'd0; data_b = 16'h0100;
    step();
    chk("tie3_gnt_a", {15'd0, gnt_a}, 16'd1);
    chk("tie3_gnt_b", {15'd0, gnt_b}, 16'd0);
    req_a = 1'b0; req_b = 1'b0;
    step();
    chk("tie3_result", result, 16'h0012);
    step();

    // Wrap and bitwise ops from acc = 0
    do_reset();
    op_cycle(1'b0, 2'd1, 16'h0001, 16'hFFFF);
    op_cycle(1'b1, 2'd0, 16'h0001, 16'h0000);
    op_cycle(1'b0, 2'd3, 16'h00F0, 16'h00F0);
    op_cycle(1'b1, 2'd2, 16'h0030, 16'h0030);

    // Reset during EXEC aborts the operation
    req_a = 1'b1; op_a = 2'd0; data_a = 16'h0100;
    step();
    chk("abort_gnt", {15'd0, gnt_a}, 16'd1);
    req_a = 1'b0;
    reset = 1'b0;
    step();
    chk("abort_done", {15'd0, done}, 16'd0);
    chk("abort_busy", {15'd0, busy}, 16'd0);
    chk("abort_acc", acc_out, 16'h0000);
    reset = 1'b1;
    step();
    chk("abort_done2", {15'd0, done}, 16'd0);
    chk("abort_acc2", acc_out, 16'h0000);

    // Clear has priority over a request in IDLE
    op_cycle(1'b0, 2'd0, 16'h1234, 16'h1234);
    clr = 1'b1;
    req_b = 1'b1; op_b = 2'd0; data_b = 16'h0001;
    step();
    chk("clr_acc", acc_out, 16'h0000);
    chk("clr_gnt_b", {15'd0, gnt_b}, 16'd0);
    chk("clr_busy", {15'd0, busy}, 16'd0);
    clr = 1'b0;
    step();
    chk("clr_next_gnt_b", {15'd0, gnt_b}, 16'd1);
    req_b = 1'b0;
    step();
    chk("clr_done", {15'd0, done}, 16'd1);
    chk("clr_result", result, 16'h0001);
    chk("clr_owner", {15'd0, owner}, 16'd1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
